// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side PRBS checker; self-synchronises to the LFSR word stream, then flywheels.
// Latency: 1 cycle from a sampled valid word to err_o / locked_o / counter updates.
// Backpressure: none; every valid word is consumed in the cycle it is presented.
//
// Ports:
//   clk          sole clock
//   rst_n        asynchronous active-low reset
//   clear_i      synchronous clear of the three statistics counters (wins over a same-cycle increment)
//   valid_i      data_i carries one LFSR step this cycle; idle cycles do not advance the prediction
//   data_i       received word
//   locked_o     checker is in LOCKED
//   err_o        one-cycle pulse: the previous valid word mismatched while LOCKED
//   err_words_o  erroneous words seen while LOCKED (saturating)
//   err_bits_o   erroneous bits seen while LOCKED (saturating)
//   words_o      words checked while LOCKED (saturating)
//
// Build option: define LFSR_CHECKER_BITCNT_EN to compile in the per-word popcount
// behind err_bits_o. Without it, err_bits_o is tied to zero and no popcount logic exists.

module lfsr_checker #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LFSR_POLY  = 32'h0000_6000,
   parameter int unsigned LFSR_LEN   = 15,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 8,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  locked_o,
   output logic                  err_o,
   output logic [CNT_WIDTH-1:0]  err_words_o,
   output logic [CNT_WIDTH-1:0]  err_bits_o,
   output logic [CNT_WIDTH-1:0]  words_o
);

   // ------------------------------------------------------------------
   // Parameter sanity checks (elaboration time)
   // ------------------------------------------------------------------
   generate
      if (DATA_WIDTH < LFSR_LEN) begin : g_chk_width
         $error("lfsr_checker: DATA_WIDTH must be >= LFSR_LEN");
      end
      if (LOCK_CNT < 1 || LOCK_CNT > 255) begin : g_chk_lock
         $error("lfsr_checker: LOCK_CNT must be in 1..255");
      end
      if (UNLOCK_CNT < 1 || UNLOCK_CNT > 255) begin : g_chk_unlock
         $error("lfsr_checker: UNLOCK_CNT must be in 1..255");
      end
   endgenerate

   localparam logic [DATA_WIDTH-1:0] POLY_MASK = DATA_WIDTH'(LFSR_POLY);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;
   localparam logic [7:0]            LOCK_THR  = 8'(LOCK_CNT);
   localparam logic [7:0]            UNLK_THR  = 8'(UNLOCK_CNT);

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   // One generator clock: shift the whole word left, feedback from the tapped bits.
   function automatic logic [DATA_WIDTH-1:0] lfsr_step(input logic [DATA_WIDTH-1:0] w);
      return {w[DATA_WIDTH-2:0], ^(w & POLY_MASK)};
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] ref_q, ref_d;
   logic                  ref_ok_q, ref_ok_d;
   logic [7:0]            run_q, run_d;
   logic [7:0]            bad_q, bad_d;
   logic                  err_q, err_d;
   logic [CNT_WIDTH-1:0]  err_words_q, err_words_d;
   logic [CNT_WIDTH-1:0]  words_q, words_d;

   logic [DATA_WIDTH-1:0] pred;       // step(ref): next expected word in either state
   logic                  match;
   logic                  data_nz;
   logic [7:0]            run_inc;
   logic [7:0]            bad_inc;
   logic                  word_hit;   // a valid word is being checked while LOCKED
   logic                  err_hit;    // ... and it mismatched

   assign pred    = lfsr_step(ref_q);
   assign match   = (data_i == pred);
   assign data_nz = |data_i;
   // Neither counter can wrap: each is cleared or acted on when it hits its threshold (<= 255).
   assign run_inc = run_q + 8'd1;
   assign bad_inc = bad_q + 8'd1;

   // ------------------------------------------------------------------
   // FSM: next state, reference and sync/loss counters
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      ref_ok_d = ref_ok_q;
      run_d    = run_q;
      bad_d    = bad_q;
      err_d    = 1'b0;
      word_hit = 1'b0;
      err_hit  = 1'b0;

      if (valid_i) begin
         if (state_q == ST_SEARCH) begin
            // Received data reseeds the reference every word while searching.
            ref_d    = data_i;
            ref_ok_d = 1'b1;
            // Zero is a fixed point of the step function, so it never counts toward lock.
            if (ref_ok_q && match && data_nz) begin
               run_d = run_inc;
               if (run_inc == LOCK_THR) begin
                  state_d = ST_LOCKED;
                  bad_d   = 8'd0;
               end
            end else begin
               run_d = 8'd0;
            end
         end else begin
            // Flywheel: the prediction advances on its own; received data is only compared.
            ref_d    = pred;
            word_hit = 1'b1;
            if (!match) begin
               err_d   = 1'b1;
               err_hit = 1'b1;
               bad_d   = bad_inc;
               if (bad_inc == UNLK_THR) begin
                  // Lost sync: restart the search seeded by the word that broke lock.
                  state_d = ST_SEARCH;
                  run_d   = 8'd0;
                  ref_d   = data_i;
               end
            end else begin
               bad_d = 8'd0;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Statistics counters (saturating, clear has priority)
   // ------------------------------------------------------------------
   always_comb begin
      words_d = words_q;
      if (clear_i) begin
         words_d = '0;
      end else if (word_hit && (words_q != CNT_MAX)) begin
         words_d = words_q + 1'b1;
      end
   end

   always_comb begin
      err_words_d = err_words_q;
      if (clear_i) begin
         err_words_d = '0;
      end else if (err_hit && (err_words_q != CNT_MAX)) begin
         err_words_d = err_words_q + 1'b1;
      end
   end

`ifdef LFSR_CHECKER_BITCNT_EN
   localparam int PCW  = $clog2(DATA_WIDTH + 1);
   // Wide enough for counter + popcount without wrapping, so overflow is a plain compare.
   localparam int SUMW = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;

   function automatic logic [PCW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
      logic [PCW-1:0] c;
      c = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         c = c + PCW'(v[i]);
      end
      return c;
   endfunction

   logic [CNT_WIDTH-1:0] err_bits_q, err_bits_d;
   logic [PCW-1:0]       bit_errs;
   logic [SUMW-1:0]      bits_sum;

   assign bit_errs = popcount(data_i ^ pred);
   assign bits_sum = SUMW'(err_bits_q) + SUMW'(bit_errs);

   always_comb begin
      err_bits_d = err_bits_q;
      if (clear_i) begin
         err_bits_d = '0;
      end else if (err_hit) begin
         if (bits_sum > SUMW'(CNT_MAX)) begin
            err_bits_d = CNT_MAX;
         end else begin
            err_bits_d = bits_sum[CNT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_bits_q <= '0;
      end else begin
         err_bits_q <= err_bits_d;
      end
   end

   assign err_bits_o = err_bits_q;
`else
   assign err_bits_o = '0;
`endif

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_SEARCH;
         ref_q       <= '0;
         ref_ok_q    <= 1'b0;
         run_q       <= 8'd0;
         bad_q       <= 8'd0;
         err_q       <= 1'b0;
         err_words_q <= '0;
         words_q     <= '0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         ref_ok_q    <= ref_ok_d;
         run_q       <= run_d;
         bad_q       <= bad_d;
         err_q       <= err_d;
         err_words_q <= err_words_d;
         words_q     <= words_d;
      end
   end

   assign locked_o    = (state_q == ST_LOCKED);
   assign err_o       = err_q;
   assign err_words_o = err_words_q;
   assign words_o     = words_q;

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;

   localparam int     LOCK   = 4;
   localparam int     UNLOCK = 8;
   localparam longint MAX32  = 64'h0000_0000_FFFF_FFFF;
   localparam longint MAX4   = 64'd15;
`ifdef LFSR_CHECKER_BITCNT_EN
   localparam bit BITCNT = 1'b1;
`else
   localparam bit BITCNT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear_i;
   logic        valid_i;
   logic [31:0] data_i;

   logic        locked_o, err_o;
   logic [31:0] err_words_o, err_bits_o, words_o;
   logic        locked4_o, err4_o;
   logic [3:0]  err_words4_o, err_bits4_o, words4_o;

   always #5 clk = ~clk;

   lfsr_checker dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .locked_o    (locked_o),
      .err_o       (err_o),
      .err_words_o (err_words_o),
      .err_bits_o  (err_bits_o),
      .words_o     (words_o)
   );

   lfsr_checker #(.CNT_WIDTH(4)) dut4 (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .locked_o    (locked4_o),
      .err_o       (err4_o),
      .err_words_o (err_words4_o),
      .err_bits_o  (err_bits4_o),
      .words_o     (words4_o)
   );

   // ---------------- counters and scoreboard ----------------
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit     locked;
      bit     err;
      longint ew, eb, w, ew4, eb4, w4;
   } exp_t;
   exp_t sb_q[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- generator and reference model ----------------
   function automatic logic [31:0] gstep(input logic [31:0] w);
      logic fb;
      fb = ^(w & 32'h0000_6000);
      return {w[30:0], fb};
   endfunction

   function automatic longint sat(input longint x, input longint mx);
      return (x > mx) ? mx : x;
   endfunction

   logic [31:0] g;
   bit          m_locked, m_ref_ok, m_err;
   logic [31:0] m_ref;
   int          m_run, m_bad;
   longint      m_ew, m_eb, m_w, m_ew4, m_eb4, m_w4;

   task automatic m_reset();
      m_locked = 0; m_ref_ok = 0; m_err = 0; m_ref = '0; m_run = 0; m_bad = 0;
      m_ew = 0; m_eb = 0; m_w = 0; m_ew4 = 0; m_eb4 = 0; m_w4 = 0;
   endtask

   task automatic model_step(input bit v, input logic [31:0] d, input bit clr);
      logic [31:0] e;
      int          pc;
      m_err = 0;
      if (v) begin
         if (!m_locked) begin
            if (m_ref_ok && d == gstep(m_ref) && d != 32'h0) m_run++;
            else m_run = 0;
            m_ref    = d;
            m_ref_ok = 1;
            if (m_run == LOCK) begin
               m_locked = 1;
               m_bad    = 0;
            end
         end else begin
            e     = gstep(m_ref);
            m_ref = e;
            m_w   = sat(m_w + 1, MAX32);
            m_w4  = sat(m_w4 + 1, MAX4);
            if (d != e) begin
               pc    = BITCNT ? $countones(d ^ e) : 0;
               m_err = 1;
               m_ew  = sat(m_ew + 1, MAX32);
               m_ew4 = sat(m_ew4 + 1, MAX4);
               m_eb  = sat(m_eb + pc, MAX32);
               m_eb4 = sat(m_eb4 + pc, MAX4);
               m_bad++;
               if (m_bad == UNLOCK) begin
                  m_locked = 0;
                  m_run    = 0;
                  m_ref    = d;
               end
            end else begin
               m_bad = 0;
            end
         end
      end
      if (clr) begin
         m_ew = 0; m_eb = 0; m_w = 0; m_ew4 = 0; m_eb4 = 0; m_w4 = 0;
      end
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL scoreboard_empty: observed 0 entries, expected 1");
         return;
      end
      e = sb_q.pop_front();
      check("sb_locked",  locked_o,     e.locked);
      check("sb_err",     err_o,        e.err);
      check("sb_ewords",  err_words_o,  e.ew);
      check("sb_ebits",   err_bits_o,   e.eb);
      check("sb_words",   words_o,      e.w);
      check("sb4_locked", locked4_o,    e.locked);
      check("sb4_err",    err4_o,       e.err);
      check("sb4_ewords", err_words4_o, e.ew4);
      check("sb4_ebits",  err_bits4_o,  e.eb4);
      check("sb4_words",  words4_o,     e.w4);
   endtask

   // Drive one cycle (inputs set just after a rising edge), predict, then compare after the next edge.
   task automatic drive(input bit v, input logic [31:0] d, input bit clr);
      exp_t e;
      valid_i = v;
      data_i  = d;
      clear_i = clr;
      model_step(v, d, clr);
      e.locked = m_locked; e.err = m_err;
      e.ew = m_ew; e.eb = m_eb; e.w = m_w;
      e.ew4 = m_ew4; e.eb4 = m_eb4; e.w4 = m_w4;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_front();
   endtask

   task automatic gen_word();
      drive(1'b1, g, 1'b0);
      g = gstep(g);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: observed no completion, expected summary before timeout");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int          nbeats;
      longint      exp_bits;
      bit          err_seen;

      rst_n = 1'b0; valid_i = 1'b0; clear_i = 1'b0; data_i = '0;
      m_reset();
      #12;
      check("rst_locked", locked_o,    0);
      check("rst_err",    err_o,       0);
      check("rst_ewords", err_words_o, 0);
      check("rst_ebits",  err_bits_o,  0);
      check("rst_words",  words_o,     0);
      check("rst4_words", words4_o,    0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All-zero words never lock.
      for (int i = 0; i < 20; i++) drive(1'b1, 32'h0, 1'b0);
      check("zero_locked", locked_o,    0);
      check("zero_words",  words_o,     0);
      check("zero_ewords", err_words_o, 0);

      // Clean stream from seed 1: locks after the 5th word.
      g = 32'h1;
      for (int i = 0; i < 4; i++) gen_word();
      check("lock_after4", locked_o, 0);
      gen_word();
      check("lock_after5", locked_o, 1);

      err_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         gen_word();
         if (err_o !== 1'b0) err_seen = 1;
      end
      check("clean_words",   words_o,     1000);
      check("clean_ewords",  err_words_o, 0);
      check("clean_errseen", err_seen,    0);
      check("clean_words4",  words4_o,    15);

      // Single-bit error.
      drive(1'b0, 32'h0, 1'b1);
      check("clr_words", words_o, 0);
      drive(1'b1, g ^ 32'h1, 1'b0);
      g = gstep(g);
      check("flip_err",    err_o,       1);
      check("flip_ewords", err_words_o, 1);
      check("flip_ebits",  err_bits_o,  BITCNT ? 1 : 0);
      check("flip_locked", locked_o,    1);
      gen_word();
      check("flip_next_err",    err_o,       0);
      check("flip_next_locked", locked_o,    1);
      check("flip_next_ewords", err_words_o, 1);

      // Eight all-ones words drop lock.
      drive(1'b0, 32'h0, 1'b1);
      exp_bits = 0;
      for (int i = 0; i < 8; i++) begin
         exp_bits += $countones(~g);
         drive(1'b1, 32'hFFFF_FFFF, 1'b0);
         g = gstep(g);
         if (i == 6) check("ones_locked7", locked_o, 1);
      end
      check("ones_locked8", locked_o,    0);
      check("ones_ewords",  err_words_o, 8);
      check("ones_ebits",   err_bits_o,  BITCNT ? exp_bits : 0);
      for (int i = 0; i < 5; i++) begin
         gen_word();
         if (i == 3) check("relock_after4", locked_o, 0);
      end
      check("relock_after5", locked_o, 1);

      // 30% valid duty, random data on idle cycles.
      drive(1'b0, 32'h0, 1'b1);
      nbeats = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 99) < 30) begin
            gen_word();
            nbeats++;
         end else begin
            drive(1'b0, $urandom, 1'b0);
         end
      end
      check("duty_words",  words_o,     nbeats);
      check("duty_ewords", err_words_o, 0);
      check("duty_locked", locked_o,    1);

      // Clear in the same cycle as an error word.
      drive(1'b1, g ^ 32'h0000_0100, 1'b1);
      g = gstep(g);
      check("clrerr_err",    err_o,       1);
      check("clrerr_ewords", err_words_o, 0);
      check("clrerr_ebits",  err_bits_o,  0);
      check("clrerr_words",  words_o,     0);
      check("clrerr_locked", locked_o,    1);

      // Saturation of the 4-bit counters: isolated errors never drop lock.
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, g ^ 32'h1, 1'b0);
         g = gstep(g);
         gen_word();
         if (i == 13) check("sat4_ewords14", err_words4_o, 14);
      end
      check("sat4_ewords", err_words4_o, 15);
      check("sat4_ebits",  err_bits4_o,  BITCNT ? 15 : 0);
      check("sat_ewords",  err_words_o,  17);
      check("sat_locked",  locked_o,     1);

      // Mid-stream reset, then resynchronise from a fresh seed.
      valid_i = 1'b0;
      clear_i = 1'b0;
      rst_n   = 1'b0;
      #2;
      check("mrst_locked", locked_o,    0);
      check("mrst_words",  words_o,     0);
      check("mrst_ewords", err_words_o, 0);
      m_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         gen_word();
         if (i == 3) check("mrst_lock4", locked_o, 0);
      end
      check("mrst_lock5", locked_o, 1);
      check("mrst_err",   err_o,    0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
